// File: rtl/gray_readout_pkg.sv
// Shared types and helpers for the gray-coded pixel readout path.
// Holds the FIFO entry struct, index width and the gray-to-binary decoder.
// The entry struct is sized by GR_WIDTH / GR_NPIX; the top-level WIDTH and
// NPIX parameters default to these and are expected to match them.
// Optional field: sat (present when GRAY_READOUT_SAT_FLAG_EN is defined).
package gray_readout_pkg;

    localparam int GR_WIDTH = 8;
    localparam int GR_NPIX  = 4;
    localparam int IDX_W    = $clog2(GR_NPIX);

    typedef struct packed {
        logic [GR_WIDTH-1:0] data;
        logic [IDX_W-1:0]    index;
        logic                last;
`ifdef GRAY_READOUT_SAT_FLAG_EN
        logic                sat;
`endif
    } entry_t;

    // Binary bit i is the XOR of all gray bits at or above i.
    function automatic logic [GR_WIDTH-1:0] gray2bin(
        input logic [GR_WIDTH-1:0] g
    );
        logic [GR_WIDTH-1:0] b;
        b = '0;
        b[GR_WIDTH-1] = g[GR_WIDTH-1];
        for (int i = GR_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_readout_fifo.sv
// Synchronous FIFO for decoded readout entries, parameterised by entry type.
// Ports: clk, reset (async high), push/din, pop/dout, count, empty.
// dout shows the head entry; when empty it holds the last popped entry.
module gray_readout_fifo #(
    parameter type entry_t = logic,
    parameter int  DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 din,
    input  logic                   pop,
    output entry_t                 dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem [DEPTH];
    entry_t          hold;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves the same edge.
    assign do_push = push && (!full || do_pop);

    // Empty FIFO keeps presenting the last entry that left it.
    assign dout = empty ? hold : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold   <= mem[rd_ptr];
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gray_readout.sv
// Gray-coded ADC sample readout: decode to binary, tag with frame index.
// Ports: clk, reset, in_valid/in_ready/in_gray, out_valid/out_ready,
// out_data, out_index, out_last (+ out_sat with GRAY_READOUT_SAT_FLAG_EN).
module gray_readout
    import gray_readout_pkg::*;
#(
    parameter int WIDTH = GR_WIDTH,
    parameter int NPIX  = GR_NPIX,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_gray,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(NPIX)-1:0] out_index,
    output logic                    out_last
`ifdef GRAY_READOUT_SAT_FLAG_EN
    ,
    output logic                    out_sat
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              up;
    logic [IDX_W-1:0]  idx;
    logic              s1_valid;
    logic [WIDTH-1:0]  s1_gray;
    logic [IDX_W-1:0]  s1_idx;
    logic              s2_valid;
    entry_t            s2_entry;
    entry_t            nxt_entry;
    entry_t            head;
    logic [WIDTH-1:0]  bin;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic              empty;
    logic              accept;
    logic              pop;
    logic              idx_wrap;

    // Entries in flight count against FIFO space, so in_ready depends
    // only on registers and never on out_ready.
    always_comb begin
        occ = (CW+1)'(count) + (CW+1)'(s1_valid) + (CW+1)'(s2_valid);
    end

    assign in_ready  = up && (occ < (CW+1)'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign idx_wrap  = (idx == IDX_W'(NPIX - 1));

    always_comb begin
        nxt_entry       = '0;
        bin             = gray2bin(s1_gray);
        nxt_entry.data  = bin;
        nxt_entry.index = s1_idx;
        nxt_entry.last  = (s1_idx == IDX_W'(NPIX - 1));
`ifdef GRAY_READOUT_SAT_FLAG_EN
        // All-ones means the ramp ran out before the comparator fired.
        nxt_entry.sat   = &bin;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up       <= 1'b0;
            idx      <= '0;
            s1_valid <= 1'b0;
            s1_gray  <= '0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_entry <= '0;
        end else begin
            up       <= 1'b1;
            s1_valid <= accept;
            if (accept) begin
                s1_gray <= in_gray;
                s1_idx  <= idx;
                idx     <= idx_wrap ? '0 : idx + IDX_W'(1);
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_entry <= nxt_entry;
            end
        end
    end

    gray_readout_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s2_valid),
        .din   (s2_entry),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    assign out_data  = head.data;
    assign out_index = head.index;
    assign out_last  = head.last;
`ifdef GRAY_READOUT_SAT_FLAG_EN
    assign out_sat   = head.sat;
`endif

endmodule

// File: tb/tb_gray_readout.sv
// Directed self-checking bench for gray_readout.
// Covers reset, latency, decode sweep, backpressure, framing, reset mid-frame.
module tb_gray_readout;

    localparam int W     = 8;
    localparam int NPIX  = 4;
    localparam int DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [W-1:0]            in_gray;
    logic                    out_valid;
    logic                    out_ready;
    logic [W-1:0]            out_data;
    logic [$clog2(NPIX)-1:0] out_index;
    logic                    out_last;
`ifdef GRAY_READOUT_SAT_FLAG_EN
    logic                    out_sat;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_readout #(
        .WIDTH (W),
        .NPIX  (NPIX),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_gray   (in_gray),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
`ifdef GRAY_READOUT_SAT_FLAG_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    function automatic logic [7:0] to_gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_gray   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Stream n samples base, base+1, ... and check every popped output.
    task automatic stream(input string tag, input int n,
                          input logic [7:0] base, input bit bp);
        int         tx;
        int         rx;
        int         cyc;
        bit         a;
        bit         p;
        logic [7:0] e;
        tx  = 0;
        rx  = 0;
        cyc = 0;
        while ((tx < n || rx < n) && cyc < 20 * n + 50) begin
            in_valid  = (tx < n);
            in_gray   = to_gray(base + 8'(tx));
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            a = in_valid && in_ready;
            p = out_valid && out_ready;
            if (p) begin
                e = base + 8'(rx);
                check({tag, "_data"}, out_data, e);
                check({tag, "_index"}, out_index, rx % NPIX);
                check({tag, "_last"}, out_last, (rx % NPIX) == NPIX - 1);
                rx++;
            end
            @(posedge clk);
            #1;
            if (a) tx++;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_count"}, rx, n);
    endtask

    int acc;
    int got;
    int n;
    bit a;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_gray   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);

        reset = 1'b0;
        #1;
        check("rdy_before_edge", in_ready, 0);
        tick();
        check("rdy_after_edge", in_ready, 1);

        // Latency: accept at edge k, out_valid from edge k+2.
        in_valid = 1'b1;
        in_gray  = 8'h03;
        tick();
        in_valid = 1'b0;
        check("lat_k", out_valid, 0);
        tick();
        check("lat_k1", out_valid, 0);
        tick();
        check("lat_k2_valid", out_valid, 1);
        check("lat_k2_data", out_data, 8'h02);
        check("lat_k2_index", out_index, 0);
        check("lat_k2_last", out_last, 0);
        out_ready = 1'b1;
        tick();
        check("empty_valid", out_valid, 0);
        check("empty_hold", out_data, 8'h02);

        // Full gray sweep, 8'h80 must decode to 8'hFF at the end.
        do_reset();
        stream("sweep", 256, 8'h00, 1'b0);

        // Frame marking, then random output stalls.
        do_reset();
        stream("frame", 2 * NPIX, 8'h50, 1'b0);
        stream("rnd", 12, 8'h90, 1'b1);

        // Backpressure: exactly DEPTH accepted, then drained in order.
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_gray  = to_gray(8'd10 + 8'(acc));
            #1;
            a = in_ready;
            tick();
            if (a) acc++;
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, DEPTH);
        check("bp_in_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_head_held", out_data, 8'd10);
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                check("bp_drain", out_data, 10 + got);
                got++;
            end
            tick();
        end
        check("bp_drained", got, DEPTH);

        // Reset mid-frame discards everything in flight.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_gray   = to_gray(8'h21);
        tick();
        in_gray   = to_gray(8'h22);
        tick();
        in_valid  = 1'b0;
        tick();
        tick();
        check("mid_pre_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_index", out_index, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_ready", in_ready, 0);
        tick();
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_gray   = to_gray(8'h33);
        tick();
        in_valid  = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check("mid_post_valid", out_valid, 1);
        check("mid_post_index", out_index, 0);
        check("mid_post_data", out_data, 8'h33);
        tick();

`ifdef GRAY_READOUT_SAT_FLAG_EN
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_gray   = 8'h80;
        tick();
        in_valid  = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check("sat_hi_data", out_data, 8'hFF);
        check("sat_hi", out_sat, 1);
        tick();
        in_valid  = 1'b1;
        in_gray   = 8'hC0;
        tick();
        in_valid  = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check("sat_lo_data", out_data, 8'h80);
        check("sat_lo", out_sat, 0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
